// File: rtl/risc1_mem_pkg.sv
// Shared types and defaults for the memory port arbiter.
//   arb_state_e : arbiter FSM states (idle, strobe asserted, strobe released)
//   owner_e     : which requester owns the current memory access
package risc1_mem_pkg;

  localparam int unsigned DefAddrW = 8;
  localparam int unsigned DefDataW = 8;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StRelease
  } arb_state_e;

  typedef enum logic {
    OwnFetch = 1'b0,
    OwnData  = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_rr_pick.sv
// Two-way round-robin picker between the fetch and data ports.
//   req_fetch_i  : fetch port requesting
//   req_data_i   : data port requesting
//   last_owner_i : port granted most recently
//   gnt_o        : one-hot grant, [0] = fetch, [1] = data
module mem_rr_pick
  import risc1_mem_pkg::*;
(
  input  logic       req_fetch_i,
  input  logic       req_data_i,
  input  owner_e     last_owner_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (req_fetch_i && req_data_i) begin
      // On a tie the port that did not go last wins.
      gnt_o = (last_owner_i == OwnFetch) ? 2'b10 : 2'b01;
    end else if (req_fetch_i) begin
      gnt_o = 2'b01;
    end else if (req_data_i) begin
      gnt_o = 2'b10;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Sole master of the byte memory: arbitrates instruction fetch against data load/store and
// runs each granted access as a four-phase level handshake (strobe up, ready up, strobe down,
// ready down), with a per-phase timeout that completes the access with an error flag.
//   clk, reset        : clock, asynchronous active-high reset
//   if_*              : fetch port (req/addr in; gnt, done, rdata, err out)
//   d_*               : data port (req/we/addr/wdata in; gnt, done, rdata, err out)
//   mem_*             : memory accessor (read/write strobes, address, write value out;
//                       read value, ready in)
module mem_port_arbiter
  import risc1_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_value,
  input  logic [DATA_W-1:0] mem_read_value,
  input  logic              mem_ready
);

  localparam int unsigned   CntW    = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  arb_state_e        state_q;
  owner_e            owner_q;
  owner_e            last_owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [CntW-1:0]   cnt_q;
  logic              err_q;
  logic [DATA_W-1:0] rd_stage_q;
  logic              rd_valid_q;
  logic              if_done_q;
  logic              if_err_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic              d_done_q;
  logic              d_err_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic [1:0] pick_gnt;
  logic       grant_any;
  logic       pick_data;
  logic       pick_write;
  logic       rel_done;
  logic       done_err;

  mem_rr_pick u_pick (
    .req_fetch_i  (if_req),
    .req_data_i   (d_req),
    .last_owner_i (last_owner_q),
    .gnt_o        (pick_gnt)
  );

  // Grants are only offered while idle and never while reset is held.
  assign grant_any  = (state_q == StIdle) && !reset && (pick_gnt != 2'b00);
  assign pick_data  = pick_gnt[1];
  assign pick_write = pick_data && d_we;

  // Release ends on ready low, or on ready stuck high for the full timeout.
  assign rel_done = !mem_ready || (cnt_q == CntLast);
  assign done_err = err_q || mem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_q      <= OwnFetch;
      last_owner_q <= OwnFetch;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      rd_stage_q   <= '0;
      rd_valid_q   <= 1'b0;
      if_done_q    <= 1'b0;
      if_err_q     <= 1'b0;
      if_rdata_q   <= '0;
      d_done_q     <= 1'b0;
      d_err_q      <= 1'b0;
      d_rdata_q    <= '0;
    end else begin
      if_done_q <= 1'b0;
      if_err_q  <= 1'b0;
      d_done_q  <= 1'b0;
      d_err_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_any) begin
            owner_q      <= pick_data ? OwnData : OwnFetch;
            last_owner_q <= pick_data ? OwnData : OwnFetch;
            we_q         <= pick_write;
            addr_q       <= pick_data ? d_addr : if_addr;
            wdata_q      <= pick_data ? d_wdata : '0;
            mem_read_q   <= !pick_write;
            mem_write_q  <= pick_write;
            err_q        <= 1'b0;
            rd_valid_q   <= 1'b0;
            cnt_q        <= '0;
            state_q      <= StReq;
          end
        end
        StReq: begin
          if (mem_ready) begin
            // Staged so the port's rdata only changes together with its done pulse.
            rd_stage_q  <= mem_read_value;
            rd_valid_q  <= !we_q;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= StRelease;
          end else if (cnt_q == CntLast) begin
            err_q       <= 1'b1;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= StRelease;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRelease: begin
          if (rel_done) begin
            cnt_q   <= '0;
            state_q <= StIdle;
            if (owner_q == OwnData) begin
              d_done_q <= 1'b1;
              d_err_q  <= done_err;
              if (rd_valid_q) d_rdata_q <= rd_stage_q;
            end else begin
              if_done_q <= 1'b1;
              if_err_q  <= done_err;
              if (rd_valid_q) if_rdata_q <= rd_stage_q;
            end
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign if_gnt          = grant_any && !pick_data;
  assign d_gnt           = grant_any && pick_data;
  assign if_done         = if_done_q;
  assign if_err          = if_err_q;
  assign if_rdata        = if_rdata_q;
  assign d_done          = d_done_q;
  assign d_err           = d_err_q;
  assign d_rdata         = d_rdata_q;
  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign mem_address     = addr_q;
  assign mem_write_value = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 16;

  typedef enum int {MemNormal, MemStuck0, MemStuck1} mem_mode_e;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, if_gnt, if_done, if_err;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_gnt, d_done, d_err;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_read, mem_write, mem_ready;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_value, mem_read_value;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  mem_mode_e mode = MemNormal;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_value(mem_write_value), .mem_read_value(mem_read_value), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 7 + 3);
  endfunction

  // Memory: ready follows the strobe level in normal mode, or is stuck low/high.
  logic [7:0] mem [128];
  always_comb begin
    case (mode)
      MemStuck0: mem_ready = 1'b0;
      MemStuck1: mem_ready = 1'b1;
      default:   mem_ready = mem_read | mem_write;
    endcase
  end
  assign mem_read_value = mem[mem_address[6:0]];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 128; i++) mem[i] <= pat(i);
    end else if (mem_write && mem_ready) begin
      mem[mem_address[6:0]] <= mem_write_value;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Transaction-level model: each grant schedules its strobe window and done cycle.
  logic       m_busy, m_last, m_own, m_we, m_err, m_upd;
  logic [7:0] m_addr, m_wdata, m_val, e_if_rd, e_d_rd;
  int         m_done, m_lo, m_hi;
  logic [7:0] model_mem [128];
  int         rd_hi_cnt = 0;
  int         d_done_cnt = 0;

  always @(negedge clk) begin
    logic e_if_gnt, e_d_gnt, e_if_done, e_d_done, e_if_err, e_d_err, e_rd, e_wr, tk;
    if (reset) begin
      m_busy  = 1'b0;
      m_last  = 1'b0;
      e_if_rd = '0;
      e_d_rd  = '0;
      for (int i = 0; i < 128; i++) model_mem[i] = pat(i);
      chk("rst_ctrl", {24'd0, if_gnt, if_done, if_err, d_gnt, d_done, d_err, mem_read,
                       mem_write}, 32'd0);
      chk("rst_data", {if_rdata, d_rdata, mem_address, mem_write_value}, 32'd0);
    end else begin
      if (mem_read) rd_hi_cnt++;
      if (d_done) d_done_cnt++;
      {e_if_gnt, e_d_gnt, e_if_done, e_d_done, e_if_err, e_d_err, e_rd, e_wr} = '0;
      if (m_busy && cyc == m_done) begin
        m_busy = 1'b0;
        if (m_own) begin
          e_d_done = 1'b1;
          e_d_err  = m_err;
          if (m_upd) e_d_rd = m_val;
        end else begin
          e_if_done = 1'b1;
          e_if_err  = m_err;
          if (m_upd) e_if_rd = m_val;
        end
        if (m_we && !m_err) model_mem[m_addr[6:0]] = m_wdata;
      end
      if (m_busy && cyc >= m_lo && cyc <= m_hi) begin
        e_rd = !m_we;
        e_wr = m_we;
        chk("mem_address", {24'd0, mem_address}, {24'd0, m_addr});
        if (m_we) chk("mem_write_value", {24'd0, mem_write_value}, {24'd0, m_wdata});
      end
      if (!m_busy && (if_req || d_req)) begin
        tk      = (if_req && d_req) ? (m_last == 1'b0) : d_req;
        e_d_gnt = tk;
        e_if_gnt = !tk;
        m_last  = tk;
        m_own   = tk;
        m_busy  = 1'b1;
        m_we    = tk && d_we;
        m_addr  = tk ? d_addr : if_addr;
        m_wdata = d_wdata;
        m_done  = cyc + ((mode == MemNormal) ? 3 : 18);
        m_lo    = cyc + 1;
        m_hi    = cyc + ((mode == MemStuck0) ? 16 : 1);
        m_err   = (mode != MemNormal);
        m_upd   = !m_we && (mode != MemStuck0);
        m_val   = model_mem[m_addr[6:0]];
      end
      chk("gnt", {30'd0, if_gnt, d_gnt}, {30'd0, e_if_gnt, e_d_gnt});
      chk("done", {30'd0, if_done, d_done}, {30'd0, e_if_done, e_d_done});
      chk("err", {30'd0, if_err, d_err}, {30'd0, e_if_err, e_d_err});
      chk("strobes", {30'd0, mem_read, mem_write}, {30'd0, e_rd, e_wr});
      chk("if_rdata", {24'd0, if_rdata}, {24'd0, e_if_rd});
      chk("d_rdata", {24'd0, d_rdata}, {24'd0, e_d_rd});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_gnt(input bit dport, output int gc);
    gc = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (dport ? d_gnt : if_gnt) begin
        gc = cyc;
        break;
      end
    end
    if (gc < 0) chk("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input bit dport, output int dc, output logic [7:0] rd,
                           output logic er);
    dc = -1;
    rd = '0;
    er = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (dport ? d_done : if_done) begin
        dc = cyc;
        rd = dport ? d_rdata : if_rdata;
        er = dport ? d_err : if_err;
        break;
      end
    end
    if (dc < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int g, dn, r0, n0, n1;
    logic [7:0] rd;
    logic er;
    int ord[$];
    int gcs[$];
    int exp_ord[6];
    logic [7:0] tab[4];
    exp_ord = '{1, 0, 1, 0, 1, 0};
    tab = '{8'h03, 8'h0A, 8'h11, 8'h18};

    reset = 1'b1;
    {if_req, d_req, d_we} = '0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    tick(); tick(); tick();
    reset = 1'b0;

    // Write 0x05 <- 0xA5, then read it back.
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h05; d_wdata = 8'hA5;
    wait_gnt(1'b1, g); tick(); d_req = 1'b0;
    wait_done(1'b1, dn, rd, er);
    chk("wr_latency", dn - g, 3);
    chk("wr_err", {31'd0, er}, 0);
    tick();
    d_req = 1'b1; d_we = 1'b0;
    wait_gnt(1'b1, g); tick(); d_req = 1'b0;
    wait_done(1'b1, dn, rd, er);
    chk("rd_latency", dn - g, 3);
    chk("rd_value", {24'd0, rd}, 32'hA5);
    chk("rd_err", {31'd0, er}, 0);
    tick();

    // Both requesting straight out of reset: data first, then strict alternation.
    if_req = 1'b1; if_addr = 8'h10; d_req = 1'b1; d_addr = 8'h11; d_we = 1'b0;
    do_reset();
    r0 = cyc;
    for (int i = 0; i < 80 && ord.size() < 6; i++) begin
      @(negedge clk);
      if (d_gnt) begin ord.push_back(1); gcs.push_back(cyc); end
      else if (if_gnt) begin ord.push_back(0); gcs.push_back(cyc); end
    end
    tick();
    if_req = 1'b0; d_req = 1'b0;
    chk("rr_count", ord.size(), 6);
    for (int i = 0; i < ord.size() && i < 6; i++) chk("rr_order", ord[i], exp_ord[i]);
    if (gcs.size() > 1) begin
      chk("rr_first_gnt", gcs[0] - r0, 0);
      chk("rr_fetch_gnt", gcs[1] - r0, 3);
    end
    for (int i = 1; i < gcs.size(); i++) chk("rr_gap", gcs[i] - gcs[i-1], 3);
    wait_done(1'b0, dn, rd, er);
    chk("rr_fetch_rdata", {24'd0, rd}, 32'h73);
    tick();

    // Ready never rises: 16 strobe cycles then error, rdata unchanged.
    mode = MemStuck0;
    n0 = rd_hi_cnt;
    if_req = 1'b1; if_addr = 8'h02;
    wait_gnt(1'b0, g); tick(); if_req = 1'b0;
    wait_done(1'b0, dn, rd, er);
    chk("to_req_strobe_cycles", rd_hi_cnt - n0, 16);
    chk("to_req_latency", dn - g, 18);
    chk("to_req_err", {31'd0, er}, 1);
    chk("to_req_rdata_held", {24'd0, rd}, 32'h73);
    tick();

    // Ready stuck high after the strobe drops: error after 16 release cycles.
    mode = MemStuck1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h03;
    wait_gnt(1'b1, g); tick(); d_req = 1'b0;
    wait_done(1'b1, dn, rd, er);
    chk("to_rel_latency", dn - g, 18);
    chk("to_rel_err", {31'd0, er}, 1);
    chk("to_rel_rdata", {24'd0, rd}, 32'h18);
    tick();
    mode = MemNormal;
    tick();

    // Reset while a write strobe is up: strobe drops at once, no done.
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_wdata = 8'h3C;
    wait_gnt(1'b1, g); tick();
    chk("pre_rst_write", {31'd0, mem_write}, 1);
    n0 = d_done_cnt;
    #2 reset = 1'b1;
    #1 chk("rst_async_write", {31'd0, mem_write}, 0);
    d_req = 1'b0; d_we = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick(); tick(); tick(); tick();
    n1 = d_done_cnt;
    chk("rst_no_done", n1 - n0, 0);
    d_req = 1'b1; d_addr = 8'h05;
    wait_gnt(1'b1, g); tick(); d_req = 1'b0;
    wait_done(1'b1, dn, rd, er);
    chk("post_rst_latency", dn - g, 3);
    chk("post_rst_rdata", {24'd0, rd}, 32'h26);
    tick();

    // Back-to-back fetches with if_req held: one grant every 3 cycles.
    if_req = 1'b1; if_addr = 8'h00;
    gcs.delete();
    for (int i = 0; i < 4; i++) begin
      wait_gnt(1'b0, g);
      gcs.push_back(g);
      if (i > 0) begin
        chk("b2b_done", {31'd0, if_done}, 1);
        chk("b2b_rdata", {24'd0, if_rdata}, {24'd0, tab[i-1]});
      end
      tick();
      if (i == 3) if_req = 1'b0;
      else if_addr = 8'(i + 1);
    end
    for (int i = 1; i < gcs.size(); i++) chk("b2b_gap", gcs[i] - gcs[i-1], 3);
    wait_done(1'b0, dn, rd, er);
    chk("b2b_last_rdata", {24'd0, rd}, 32'h18);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sits directly upstream of the fixed byte memory and is the only master on the memory accessor (read, write, address, write_value, read_value, ready).
- Arbitrates between the instruction-fetch port and the data load/store port.
- Converts each granted request into the memory's four-phase level handshake: strobe high, wait for ready high, strobe low, wait for ready low.
- Returns read data or write completion to the owning port, with a timeout/error path.

Parameters:
ADDR_W, 8, address width (memory decodes low 7 bits)
DATA_W, 8, data width (one byte per access)
TIMEOUT, 16, max cycles waited in each handshake phase before error

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
if_req  input  1  fetch request, held until if_gnt
if_addr  input  ADDR_W  fetch address
if_gnt  output  1  fetch request accepted (combinational, IDLE only)
if_done  output  1  one-cycle pulse: fetch result valid
if_rdata  output  DATA_W  fetched byte, valid with if_done
if_err  output  1  timeout on fetch, valid with if_done
d_req  input  1  data request, held until d_gnt
d_we  input  1  1 = write, 0 = read
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  store byte
d_gnt  output  1  data request accepted
d_done  output  1  one-cycle pulse: load/store complete
d_rdata  output  DATA_W  loaded byte, valid with d_done
d_err  output  1  timeout on data access, valid with d_done
mem_read  output  1  memory read strobe (level)
mem_write  output  1  memory write strobe (level)
mem_address  output  ADDR_W  memory address
mem_write_value  output  DATA_W  memory write data
mem_read_value  input  DATA_W  memory read data
mem_ready  input  1  memory ready (level)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port reset.
- Reset values: all outputs 0; FSM IDLE; last_owner = FETCH, so data wins the first tie; timeout counter 0.
- Reset mid-transaction: strobes drop immediately; no done pulse for the aborted access.

FSM states: IDLE, REQ, RELEASE.
- IDLE:
  - If any req, grant one: gnt is combinational in the same cycle.
  - Latch owner, address, we and wdata; go to REQ; clear counter.
  - Both requesting: grant the port that is not last_owner (round robin).
  - Single requester: always granted.
- REQ:
  - Assert mem_read (owner is fetch, or data with d_we=0) or mem_write (data with d_we=1). Never both.
  - mem_address and mem_write_value come from registers and are stable for the whole state.
  - On mem_ready=1: capture mem_read_value into the owner's rdata register; go to RELEASE.
  - Counter reaches TIMEOUT-1 with mem_ready still 0: set err flag; go to RELEASE.
- RELEASE:
  - Strobes low.
  - On mem_ready=0: go to IDLE and pulse the owner's done in the next cycle, together with rdata and err.
  - Ready stuck high for TIMEOUT cycles: set err flag and complete the same way.
- Latency: req seen in cycle N → gnt in N, strobe in N+1, ready seen in N+1 → RELEASE in N+2, ready low seen in N+2 → done in N+3.
  - A new grant is possible in N+3, concurrent with the done pulse.
  - Best case: one access per 3 cycles.
- Output holds:
  - rdata holds its value until the next done on the same port.
  - err holds only during the done cycle.
  - On writes, d_rdata holds its previous value.
- Counter: width $clog2(TIMEOUT+1); clears on every state change; saturates and never wraps.
- last_owner updates on each grant.
- Requesters may drop req after gnt; a new req on the same port waits for IDLE.

Decomposition:
- Package risc1_mem_pkg: state enum {IDLE, REQ, RELEASE}, owner enum {OWN_FETCH, OWN_DATA}, default ADDR_W/DATA_W constants.
- Sub-module mem_rr_pick: combinational 2-way round-robin picker. Inputs: two reqs and last_owner. Outputs: one-hot grant.

Test Plan:
- Reset, then d_req write addr 0x05 data 0xA5, then d_req read 0x05 → d_done each at grant+3; read d_rdata=0xA5, d_err=0; mem_write and mem_read never high together.
- if_req and d_req both high from reset, addrs 0x10/0x11 → data granted first, fetch next (grant at cycle 3); then hold both for 4 grants → strict alternation.
- Memory model keeps ready 0 → mem_read high exactly TIMEOUT=16 cycles, then if_done with if_err=1; FSM returns to IDLE.
- Memory model keeps ready stuck 1 after strobe drop → done with err=1 after 16 RELEASE cycles.
- Assert reset in REQ of a write to 0x20 → mem_write falls asynchronously; no d_done; next request completes normally.
- Back-to-back fetches 0x00..0x03 with if_req held high → one grant per 3 cycles, if_rdata matches preloaded bytes.
